// File: rtl/seq_serializer_if.sv
// Parallel-in / serial-out bus for seq_serializer: word handshake on the
// parallel side, bit stream with stall control on the serial side.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_en;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;

  modport master (
    output din, din_valid, ser_en,
    input  din_ready, ser_out, ser_valid, word_done
  );

  modport slave (
    input  din, din_valid, ser_en,
    output din_ready, ser_out, ser_valid, word_done
  );
endinterface

// File: rtl/seq_serializer.sv
// Word-to-bit serializer with ready/valid input, stall enable and gapless
// back-to-back loading on the last bit of the current word.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  seq_serializer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
  logic             ready_c;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    word_done_d = 1'b0;
    ready_c     = 1'b0;

    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.din_valid) begin
          shreg_d   = bus.din;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_en) begin
          if (bit_cnt_q == LAST_IDX) begin
            // Last bit leaves this edge: reload without a gap or drain to idle.
            ready_c     = 1'b1;
            word_done_d = 1'b1;
            bit_cnt_d   = '0;
            if (bus.din_valid) begin
              shreg_d = bus.din;
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ser_valid_d = (state_d == SHIFT);
    ser_out_d   = (state_d == SHIFT) && head_bit(shreg_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign bus.din_ready = ready_c;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.word_done = word_done_q;

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, word width in bits; legal range 2..32.
REQ-002 Parameter: MSB_FIRST, default 1, bit order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-005 Port: din  input  WIDTH  parallel word to serialize.
REQ-006 Port: din_valid  input  1  din holds a valid word.
REQ-007 Port: din_ready  output  1  block accepts din this cycle.
REQ-008 Port: ser_en  input  1  shift enable; 0 freezes shifting (stall).
REQ-009 Port: ser_out  output  1  serial bit stream; drives the downstream sequence detector's data input.
REQ-010 Port: ser_valid  output  1  ser_out carries a word bit.
REQ-011 Port: word_done  output  1  one-cycle pulse after the last bit of a word has been shifted.

Function
REQ-012 States: IDLE (no word loaded) and SHIFT (word loaded, bits pending).
REQ-013 Handshake: a word is accepted on a rising edge where din_valid=1 and din_ready=1; din is ignored otherwise.
REQ-014 din_ready=1 in IDLE; in SHIFT, din_ready=1 only when the current bit is the last one (bit_cnt=WIDTH-1) and ser_en=1; din_ready=0 otherwise.
REQ-015 din_ready is combinational from state, bit_cnt and ser_en, and does not depend on din_valid.
REQ-016 Acceptance in IDLE: load the shift register, clear bit_cnt to 0, go to SHIFT; the first bit appears on ser_out in the next cycle (latency 1 cycle).
REQ-017 In SHIFT, ser_valid=1 and ser_out = the current bit (MSB of the shift register if MSB_FIRST=1, LSB otherwise).
REQ-018 In SHIFT with ser_en=1 and bit_cnt<WIDTH-1: shift by one position, bit_cnt+1.
REQ-019 In SHIFT with ser_en=0: shift register, bit_cnt, ser_out and ser_valid hold their values.
REQ-020 Last bit (bit_cnt=WIDTH-1, ser_en=1) with acceptance: load the new word and stay in SHIFT; the new word's first bit follows with no gap.
REQ-021 Last bit (bit_cnt=WIDTH-1, ser_en=1) without acceptance: go to IDLE.
REQ-022 word_done=1 for exactly the one cycle after each last-bit shift (REQ-020 and REQ-021 cases), and is 0 otherwise.
REQ-023 In IDLE: ser_out=0 and ser_valid=0. The idle line low keeps the downstream detector fed with zeros.
REQ-024 bit_cnt width is clog2(WIDTH); bit_cnt never exceeds WIDTH-1.
REQ-025 ser_en has no effect in IDLE, and acceptance in IDLE does not require ser_en=1.
REQ-026 All outputs are registered except din_ready.

Reset
REQ-027 While reset=0: state=IDLE, shift register=0, bit_cnt=0, ser_out=0, ser_valid=0, word_done=0.
REQ-028 With reset=0, din_ready=1 (IDLE), but no word is accepted while reset is asserted.
REQ-029 Assertion during SHIFT aborts the word immediately: no remaining bits are emitted and no word_done pulse occurs.
REQ-030 After reset deasserts, the first rising edge can accept a word.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, ser_en=1, single word din=8'h99 -> ser_out 1,0,0,1,1,0,0,1 on cycles 1..8 after acceptance; ser_valid high for exactly 8 cycles; word_done pulses once, in cycle 9; the downstream 1001 detector asserts twice.
REQ-032 Back-to-back: din_valid held high with 8'hA5 then 8'h3C -> 16 contiguous valid bits 10100101 00111100; din_ready high only in the cycle showing the 8th bit of the first word.
REQ-033 MSB_FIRST=0, din=8'h01 -> ser_out 1,0,0,0,0,0,0,0.
REQ-034 Stall: ser_en=0 for 3 cycles after the 3rd bit of 8'hF0 -> the 3rd bit is held for 4 cycles total; sequence otherwise intact; word_done delayed by 3 cycles.
REQ-035 Reset mid-word: reset=0 asynchronously after the 4th bit of 8'hFF -> ser_valid and ser_out drop to 0 without a clock edge; no word_done; next word after release serializes correctly.
REQ-036 din_valid=1 during SHIFT before the last bit -> din_ready=0, and the word is held by the source and accepted only on the last bit.
